alu: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_decoder.sv | 57 +++++
 rtl/alu.sv | 94 +++++++++
 tb/tb_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the registered MIPS-subset ALU:
// opcode/funct encodings, the internal operation enum and operand selects.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_NEG  = 0;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA
  } alu_op_t;

  typedef enum logic [1:0] {B_REG, B_SEXT, B_ZEXT} b_sel_t;
  typedef enum logic {SH_SHAMT, SH_REGA} sh_sel_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct into operation, operand-B select,
// shift-amount select and overflow enable. valid is low for unknown encodings.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    op,
  output b_sel_t     b_sel,
  output sh_sel_t    sh_sel,
  output logic       ovf_en,
  output logic       valid
);

  always_comb begin
    op     = ADD;
    b_sel  = B_REG;
    sh_sel = SH_SHAMT;
    ovf_en = 1'b0;
    valid  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin op = ADD; ovf_en = 1'b1; end
          FN_ADDU: op = ADD;
          FN_SUB:  begin op = SUB; ovf_en = 1'b1; end
          FN_SUBU: op = SUB;
          FN_AND:  op = AND;
          FN_OR:   op = OR;
          FN_XOR:  op = XOR;
          FN_NOR:  op = NOR;
          FN_SLT:  op = SLT;
          FN_SLTU: op = SLTU;
          FN_SLL:  op = SLL;
          FN_SRL:  op = SRL;
          FN_SRA:  op = SRA;
          FN_SLLV: begin op = SLL; sh_sel = SH_REGA; end
          FN_SRLV: begin op = SRL; sh_sel = SH_REGA; end
          FN_SRAV: begin op = SRA; sh_sel = SH_REGA; end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI:  begin op = ADD; b_sel = B_SEXT; ovf_en = 1'b1; end
      OP_ADDIU: begin op = ADD; b_sel = B_SEXT; end
      OP_ANDI:  begin op = AND; b_sel = B_ZEXT; end
      OP_ORI:   begin op = OR;  b_sel = B_ZEXT; end
      OP_XORI:  begin op = XOR; b_sel = B_ZEXT; end
      OP_SLTI:  begin op = SLT;  b_sel = B_SEXT; end
      OP_SLTIU: begin op = SLTU; b_sel = B_SEXT; end
      // Branch compare: zero flag carries the equality result.
      OP_BEQ, OP_BNE: op = SUB;
      OP_LW, OP_SW:   begin op = ADD; b_sel = B_SEXT; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: decodes the instruction, computes the result and
// zero/overflow/negative flags, and registers both (latency 1).
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  alu_op_t op;
  b_sel_t  b_sel;
  sh_sel_t sh_sel;
  logic    ovf_en;
  logic    valid;

  alu_decoder u_dec (
    .opcode (instruction[31:26]),
    .funct  (instruction[5:0]),
    .op     (op),
    .b_sel  (b_sel),
    .sh_sel (sh_sel),
    .ovf_en (ovf_en),
    .valid  (valid)
  );

  // Register-number fields are not needed by the ALU.
  logic unused_fields;
  assign unused_fields = ^instruction[25:16];

  logic [31:0] sext, zext, b_val, add_res, sub_res, res;
  logic [4:0]  sh;
  logic        ovf;
  logic [2:0]  flg;

  assign sext    = {{16{instruction[15]}}, instruction[15:0]};
  assign zext    = {16'h0000, instruction[15:0]};
  assign sh      = (sh_sel == SH_REGA) ? regA[4:0] : instruction[10:6];
  assign add_res = regA + b_val;
  assign sub_res = regA - b_val;

  always_comb begin
    case (b_sel)
      B_SEXT:  b_val = sext;
      B_ZEXT:  b_val = zext;
      default: b_val = regB;
    endcase
  end

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      ADD: begin
        res = add_res;
        ovf = (regA[31] == b_val[31]) && (add_res[31] != regA[31]);
      end
      SUB: begin
        res = sub_res;
        ovf = (regA[31] != b_val[31]) && (sub_res[31] != regA[31]);
      end
      AND:  res = regA & b_val;
      OR:   res = regA | b_val;
      XOR:  res = regA ^ b_val;
      NOR:  res = ~(regA | b_val);
      SLT:  res = {31'd0, $signed(regA) < $signed(b_val)};
      SLTU: res = {31'd0, regA < b_val};
      SLL:  res = b_val << sh;
      SRL:  res = b_val >> sh;
      SRA:  res = $unsigned($signed(b_val) >>> sh);
      default: res = '0;
    endcase
    if (!valid) res = '0;
    flg            = '0;
    flg[FLAG_ZERO] = valid && (res == 32'd0);
    flg[FLAG_OVF]  = valid && ovf_en && ovf;
    flg[FLAG_NEG]  = res[31];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= res;
      flags  <= flg;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases with known answers, then random instructions
// checked against an arithmetic reference model through an expected queue.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, regA, regB;
  logic [31:0] result;
  logic [2:0]  flags;

  int tests_run = 0;
  int tests_failed = 0;
  logic [34:0] exp_q[$];

  alu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .regA        (regA),
    .regB        (regB),
    .result      (result),
    .flags       (flags)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] shamt);
    return {6'h00, 5'd0, 5'd0, 5'd0, shamt, fn};
  endfunction

  // Reference model: {flags, result} straight from the operation table.
  function automatic logic [34:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [5:0]  opc, fn;
    int unsigned sh;
    logic [31:0] se, ze, r;
    longint      s;
    bit          ovf, ok;
    opc = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    r   = 32'd0;
    ovf = 1'b0;
    ok  = 1'b1;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                 ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        6'h21: r = a + b;
        6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                 ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
        6'h2B: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: r = (b >> sh) | (b[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = (b >> a[4:0]) | (b[31] ? ~(32'hFFFFFFFF >> a[4:0]) : 32'd0);
        default: ok = 1'b0;
      endcase
    end else begin
      case (opc)
        6'h08: begin s = longint'($signed(a)) + longint'($signed(se)); r = a + se;
                 ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        6'h09, 6'h23, 6'h2B: r = a + se;
        6'h0C: r = a & ze;
        6'h0D: r = a | ze;
        6'h0E: r = a ^ ze;
        6'h0A: r = (longint'($signed(a)) < longint'($signed(se))) ? 32'd1 : 32'd0;
        6'h0B: r = (longint'(a) < longint'(se)) ? 32'd1 : 32'd0;
        6'h04, 6'h05: r = a - b;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) return 35'd0;
    return {(r == 32'd0), ovf, r[31], r};
  endfunction

  // Driver: apply one operation, then check the registered output after the edge.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [34:0] expected, input string tag);
    logic [34:0] e;
    exp_q.push_back(expected);
    instruction = ins;
    regA = a;
    regB = b;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    assert ({flags, result} === e) else begin
      tests_failed++;
      $error("FAIL %s: ins=%h a=%h b=%h got flags=%b result=%h want flags=%b result=%h",
             tag, ins, a, b, flags, result, e[34:32], e[31:0]);
    end
  endtask

  task automatic check_zero(input string tag);
    tests_run++;
    assert ({flags, result} === 35'd0) else begin
      tests_failed++;
      $error("FAIL %s: got flags=%b result=%h want flags=000 result=00000000",
             tag, flags, result);
    end
  endtask

  initial begin
    logic [5:0]  ops[12];
    logic [5:0]  fns[17];
    logic [31:0] corner[6];
    logic [31:0] ins, a, b;
    ops    = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B};
    fns    = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};
    corner = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h7FFF};

    reset = 1'b1;
    instruction = rtype(6'h20, 5'd0);
    regA = 32'h1234;
    regB = 32'h1;
    @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;

    run_op(rtype(6'h20, 0), 32'h80000009, 32'h80000005, {3'b010, 32'h0000000E}, "add_ovf");
    run_op(rtype(6'h21, 0), 32'h40000009, 32'h40000005, {3'b001, 32'h8000000E}, "addu");
    run_op(rtype(6'h22, 0), 32'h80000000, 32'h00000001, {3'b010, 32'h7FFFFFFF}, "sub_ovf");
    run_op(32'h00011040,    32'h0,        32'hDDDDDDDD, {3'b001, 32'hBBBBBBBA}, "sll");
    run_op(rtype(6'h07, 0), 32'h7,        32'hDDDDDDDD, {3'b001, 32'hFFBBBBBB}, "srav");
    run_op(rtype(6'h2A, 0), 32'h3,        32'hDDDDDDDD, {3'b100, 32'h00000000}, "slt");
    run_op(rtype(6'h2B, 0), 32'h3,        32'hDDDDDDDD, {3'b000, 32'h00000001}, "sltu");
    run_op(32'h2C01906A,    32'h3,        32'h0,        {3'b000, 32'h00000001}, "sltiu");
    run_op(32'h2001FFFF,    32'hFFFFFFFF, 32'h0,        {3'b001, 32'hFFFFFFFE}, "addi");
    run_op(32'h30018000,    32'h0FFFFF03, 32'h0,        {3'b000, 32'h00008000}, "andi");
    run_op(32'h10000000,    32'h12345678, 32'h12345678, {3'b100, 32'h00000000}, "beq");
    run_op(32'h14000000,    32'hDDDDDDDC, 32'hDDDDDDDD, {3'b001, 32'hFFFFFFFF}, "bne");
    run_op(32'h8C0180FF,    32'hDDDDDDDD, 32'h0,        {3'b001, 32'hDDDD5EDC}, "lw");
    run_op(rtype(6'h3F, 0), 32'h5,        32'h5,        35'd0,                  "bad_funct");
    run_op(32'hFC000000,    32'h5,        32'h5,        35'd0,                  "bad_opcode");

    // Reset in the middle of an add stream.
    run_op(rtype(6'h20, 0), 32'h10, 32'h20, {3'b000, 32'h30}, "add_stream0");
    run_op(rtype(6'h20, 0), 32'h11, 32'h22, {3'b000, 32'h33}, "add_stream1");
    reset = 1'b1;
    regA = 32'h44;
    @(posedge clk);
    #1;
    check_zero("reset_midstream");
    reset = 1'b0;
    run_op(rtype(6'h20, 0), 32'h7, 32'h8, {3'b000, 32'hF}, "post_reset_add");

    for (int i = 0; i < 400; i++) begin
      logic [5:0] opc;
      opc = ops[$urandom_range(11, 0)];
      ins = $urandom;
      ins[31:26] = opc;
      if (opc == 6'h00) ins[5:0] = fns[$urandom_range(16, 0)];
      if ($urandom_range(9, 0) == 0) ins[31:26] = 6'h3F;
      a = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(5, 0)] : $urandom;
      b = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(5, 0)] : $urandom;
      if ($urandom_range(7, 0) == 0) b = a;
      run_op(ins, a, b, model(ins, a, b), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
